seq_bit_serializer: RTL and testbench

Parallel-to-serial front end for the sequence-detector chain. Accepts WIDTH-bit words on a valid/ready handshake and shifts them out MSB-first, one bit per clock, on the serial line `w` that feeds the 00/11 sequence detector directly downstream. A one-entry holding buffer lets consecutive words stream with no idle cycle between them. When idle, the line is driven low and flagged invalid.

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_hold_reg.sv | 36 +++
 rtl/seq_bit_serializer.sv | 141 ++++++++++++++
 tb/tb_seq_bit_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence-detector chain.
// Used by the serializer front end and its bench.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam logic SEQ_IDLE_LEVEL = 1'b0;
    localparam int   SEQ_WORD_W     = 8;

endpackage

// File: rtl/seq_hold_reg.sv
// One-entry holding buffer sitting in front of the shift register.
// A write fills it, a read empties it; write wins if both fire.
module seq_hold_reg
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    // Capture the word on write; drop the full flag once it is read out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (wr_en) begin
            data_q <= din;
            full_q <= 1'b1;
        end else if (rd_en) begin
            full_q <= 1'b0;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end, MSB first, gapless via a one-word hold.
// Define SEQ_SER_PARITY_EN to append an even-parity bit to every word.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WORD_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             w,
    output logic             w_valid,
    output logic             busy
);

`ifdef SEQ_SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SEQ_SER_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             hold_full;
    logic             hold_wr;
    logic             hold_rd;
    logic [WIDTH-1:0] hold_dout;
    logic             hs;
    logic             last;
    logic             load;
    logic [WIDTH-1:0] load_word;

    assign hs   = data_valid && data_ready;
    assign last = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    seq_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (Clk),
        .rst_n (Rst_n),
        .wr_en (hold_wr),
        .rd_en (hold_rd),
        .din   (data_in),
        .dout  (hold_dout),
        .full  (hold_full)
    );

    // Next-state: load from input or hold, shift, or fall back to idle.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        hold_wr   = 1'b0;
        hold_rd   = 1'b0;
        load      = 1'b0;
        load_word = data_in;
`ifdef SEQ_SER_PARITY_EN
        par_d     = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    if (hold_full) begin
                        load      = 1'b1;
                        load_word = hold_dout;
                        hold_rd   = 1'b1;
                    end else if (hs) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (hs) begin
                    hold_wr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = SHIFT;
            shreg_d = load_word;
            cnt_d   = '0;
`ifdef SEQ_SER_PARITY_EN
            par_d   = ^load_word;
`endif
        end
    end

    // State, shift register and bit counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef SEQ_SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Serial line: word bits MSB first, then parity on the last slot.
    always_comb begin
        w       = SEQ_IDLE_LEVEL;
        w_valid = 1'b0;
        if (state_q == SHIFT) begin
            w_valid = 1'b1;
`ifdef SEQ_SER_PARITY_EN
            w = last ? par_q : shreg_q[WIDTH-1];
`else
            w = shreg_q[WIDTH-1];
`endif
        end
    end

    assign data_ready = !hold_full;
    assign busy       = (state_q == SHIFT) || hold_full;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer, WIDTH=8.
// Honours SEQ_SER_PARITY_EN for the frame length and parity slot.
module tb_seq_bit_serializer;

`ifdef SEQ_SER_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       Clk;
    logic       Rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       w;
    logic       w_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    seq_bit_serializer #(
        .WIDTH (8)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .w          (w),
        .w_valid    (w_valid),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_bit(input logic [7:0] wd, input int k);
        if (k < 8) return wd[3'(7 - k)];
        return ^wd;
    endfunction

    // Single word from idle; checks every slot and the idle tail.
    task automatic send_single(input logic [7:0] wd, input string tag,
                               output bit lastbit);
        data_in    = wd;
        data_valid = 1'b1;
        @(posedge Clk); #1;
        data_valid = 1'b0;
        lastbit = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge Clk);
            check({tag, "_vld"}, 32'(w_valid), 32'd1);
            check({tag, "_bit"}, 32'(w), 32'(exp_bit(wd, k)));
            lastbit = w;
        end
        @(negedge Clk);
        check({tag, "_tail_vld"}, 32'(w_valid), 32'd0);
        check({tag, "_tail_w"}, 32'(w), 32'd0);
        check({tag, "_tail_busy"}, 32'(busy), 32'd0);
        @(posedge Clk); #1;
    endtask

    // Streams words in order, advancing only on a handshake.
    task automatic stream(input logic [7:0] wl[4], input int n,
                          input bit tog, input int ncyc,
                          output int nval, output int nlow,
                          output int gaps, output int bad);
        bit   got[$];
        bit   expq[$];
        int   idx;
        int   first;
        int   lastc;
        bit   hs;
        idx   = 0;
        first = -1;
        lastc = -1;
        nval  = 0;
        nlow  = 0;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < FRAME; k++)
                expq.push_back(exp_bit(wl[i], k));
        data_in    = wl[0];
        data_valid = tog ? 1'b0 : 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge Clk);
            if (w_valid) begin
                got.push_back(w);
                nval++;
                if (first < 0) first = c;
                lastc = c;
            end
            if (!data_ready) nlow++;
            hs = data_valid && data_ready;
            @(posedge Clk); #1;
            if (hs) idx++;
            if (idx < n) begin
                data_in    = wl[idx];
                data_valid = tog ? (c % 3 != 1) : 1'b1;
            end else begin
                data_valid = 1'b0;
            end
        end
        gaps = (first < 0) ? 0 : (lastc - first + 1 - nval);
        bad  = (got.size() > expq.size()) ? got.size() - expq.size()
                                          : expq.size() - got.size();
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (got[i] != expq[i]) bad++;
    endtask

    initial begin
        logic [7:0] wl[4];
        bit         lb;
        int         nval, nlow, gaps, bad, seen;
        logic [7:0] c3;

        Rst_n      = 1'b0;
        data_in    = '0;
        data_valid = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_w", 32'(w), 32'd0);
        check("rst_wvld", 32'(w_valid), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;

        // Single A5: 1,0,1,0,0,1,0,1 (+ parity 0).
        send_single(8'hA5, "a5", lb);
`ifdef SEQ_SER_PARITY_EN
        check("a5_parity", 32'(lb), 32'd0);
        send_single(8'h07, "07", lb);
        check("07_parity", 32'(lb), 32'd1);
`else
        check("a5_lsb", 32'(lb), 32'd1);
`endif

        // Back-to-back FF, 00, F0 with valid held high.
        wl[0] = 8'hFF; wl[1] = 8'h00; wl[2] = 8'hF0; wl[3] = 8'h00;
        stream(wl, 3, 1'b0, 45, nval, nlow, gaps, bad);
        check("b2b_nval", 32'(nval), 32'(3 * FRAME));
        check("b2b_gaps", 32'(gaps), 32'd0);
        check("b2b_ready_low", 32'(nlow), 32'(2 * (FRAME - 1)));
        check("b2b_bits", 32'(bad), 32'd0);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Bypass: 3C offered exactly on the last-bit cycle of 81.
        data_in    = 8'h81;
        data_valid = 1'b1;
        @(posedge Clk); #1;
        data_valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge Clk);
            check("byp_first_bit", 32'(w), 32'(exp_bit(8'h81, k)));
            if (k == FRAME - 2) begin
                @(posedge Clk); #1;
                data_in    = 8'h3C;
                data_valid = 1'b1;
            end
        end
        check("byp_ready_last", 32'(data_ready), 32'd1);
        @(posedge Clk); #1;
        data_valid = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge Clk);
            check("byp_vld", 32'(w_valid), 32'd1);
            check("byp_bit", 32'(w), 32'(exp_bit(8'h3C, k)));
            if (k == 0) check("byp_hold_empty", 32'(data_ready), 32'd1);
        end
        @(negedge Clk);
        check("byp_tail_vld", 32'(w_valid), 32'd0);
        @(posedge Clk); #1;

        // Reset during bit 3 of C3 with 55 parked in hold.
        c3         = 8'hC3;
        data_in    = c3;
        data_valid = 1'b1;
        @(posedge Clk); #1;
        data_in = 8'h55;
        @(posedge Clk); #1;
        data_valid = 1'b0;
        @(negedge Clk);
        check("rm_bit1", 32'(w), 32'(c3[6]));
        check("rm_hold_full", 32'(data_ready), 32'd0);
        check("rm_busy", 32'(busy), 32'd1);
        @(negedge Clk);
        @(negedge Clk);
        check("rm_bit3_vld", 32'(w_valid), 32'd1);
        Rst_n = 1'b0;
        #1;
        check("rm_w", 32'(w), 32'd0);
        check("rm_wvld", 32'(w_valid), 32'd0);
        check("rm_ready", 32'(data_ready), 32'd1);
        check("rm_busy0", 32'(busy), 32'd0);
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            if (w_valid || busy) seen++;
        end
        check("rm_after_quiet", 32'(seen), 32'd0);
        @(posedge Clk); #1;

        // Valid toggling while ready is low: order preserved, no loss.
        wl[0] = 8'h12; wl[1] = 8'h34; wl[2] = 8'h56; wl[3] = 8'h9A;
        stream(wl, 4, 1'b1, 70, nval, nlow, gaps, bad);
        check("tog_nval", 32'(nval), 32'(4 * FRAME));
        check("tog_bits", 32'(bad), 32'd0);
        check("tog_saw_stall", 32'(nlow > 0), 32'd1);
        check("tog_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
